// File: rtl/sync_register_file.sv
// sync_register_file
//   Clocked control/status register bank sitting between the host bus decoder
//   and the video core. Each of NUM_REGS registers is read/write, W1C status or
//   read-only, chosen per register by RW_MASK / W1C_MASK (RW wins on overlap).
//
// Ports
//   clk, reset   clock and synchronous active-high reset
//   en, rd, wr   bus access enable and read/write requests (qualified by en)
//   be           byte enables, be[k] covers data bits 8k+7:8k
//   addr         register address
//   data_in      write data
//   data_out     registered read data, holds until the next read
//   rd_valid     one-cycle pulse marking data_out as fresh
//   values_in    live values of read-only registers, register i at [i*DW +: DW]
//   set_in       event pulses that set W1C bits, same packing as values_in
//   values_out   current RW/W1C contents (0 for read-only registers)
//   wr_strobe    one-cycle pulse per RW/W1C register written
module sync_register_file #(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned NUM_REGS = 16,
   parameter logic [NUM_REGS-1:0] RW_MASK = 16'h00F2,
   parameter logic [NUM_REGS-1:0] W1C_MASK = 16'h0100
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           en,
   input  logic                           rd,
   input  logic                           wr,
   input  logic [DATA_WIDTH/8-1:0]        be,
   input  logic [ADDR_WIDTH-1:0]          addr,
   input  logic [DATA_WIDTH-1:0]          data_in,
   output logic [DATA_WIDTH-1:0]          data_out,
   output logic                           rd_valid,
   input  logic [DATA_WIDTH*NUM_REGS-1:0] values_in,
   input  logic [DATA_WIDTH*NUM_REGS-1:0] set_in,
   output logic [DATA_WIDTH*NUM_REGS-1:0] values_out,
   output logic [NUM_REGS-1:0]            wr_strobe
);

   localparam int unsigned NBYTES = DATA_WIDTH / 8;
   localparam int unsigned NSLOTS = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] be_mask;
   logic [DATA_WIDTH-1:0] rd_view [NSLOTS];
   logic [NUM_REGS-1:0]   strobe_d;

   // Only slices of these buses belong to each register kind.
   logic unused_inputs;
   assign unused_inputs = ^{values_in, set_in};

   always_comb begin
      be_mask = '0;
      for (int unsigned k = 0; k < NBYTES; k++) begin
         be_mask[k*8 +: 8] = {8{be[k]}};
      end
   end

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
      logic hit;
      assign hit = en & wr & (addr == ADDR_WIDTH'(i));

      if (RW_MASK[i]) begin : g_rw
         logic [DATA_WIDTH-1:0] cur;
         always_ff @(posedge clk) begin
            if (reset) begin
               cur <= '0;
            end else if (hit) begin
               cur <= (cur & ~be_mask) | (data_in & be_mask);
            end
         end
         assign rd_view[i] = cur;
         assign values_out[i*DATA_WIDTH +: DATA_WIDTH] = cur;
         assign strobe_d[i] = hit;
      end else if (W1C_MASK[i]) begin : g_w1c
         logic [DATA_WIDTH-1:0] cur;
         logic [DATA_WIDTH-1:0] clr;
         assign clr = hit ? (data_in & be_mask) : '0;
         // Set is OR-ed after the clear so a same-cycle event is never lost.
         always_ff @(posedge clk) begin
            if (reset) begin
               cur <= '0;
            end else begin
               cur <= (cur & ~clr) | set_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
         end
         assign rd_view[i] = cur;
         assign values_out[i*DATA_WIDTH +: DATA_WIDTH] = cur;
         assign strobe_d[i] = hit;
      end else begin : g_ro
         assign rd_view[i] = values_in[i*DATA_WIDTH +: DATA_WIDTH];
         assign values_out[i*DATA_WIDTH +: DATA_WIDTH] = '0;
         assign strobe_d[i] = 1'b0;
      end
   end

   // Unimplemented address slots read as zero.
   for (genvar j = NUM_REGS; j < NSLOTS; j++) begin : g_hole
      assign rd_view[j] = '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         data_out  <= '0;
         rd_valid  <= 1'b0;
         wr_strobe <= '0;
      end else begin
         rd_valid  <= en & rd;
         wr_strobe <= strobe_d;
         if (en & rd) begin
            data_out <= rd_view[addr];
         end
      end
   end

endmodule

// File: tb/tb_sync_register_file.sv
// tb_sync_register_file
//   Directed bench for sync_register_file built with 12 registers so that
//   out-of-range addresses exist. A behavioural model tracks register contents
//   and expected outputs; one process compares every cycle, and literal checks
//   pin the key scenarios.
module tb_sync_register_file;

   localparam int unsigned NR = 12;
   localparam int unsigned DW = 16;
   localparam logic [NR-1:0] RWM = 12'h0F2;
   localparam logic [NR-1:0] W1M = 12'h100;

   logic               clk = 1'b0;
   logic               reset;
   logic               en, rd, wr;
   logic [1:0]         be;
   logic [3:0]         addr;
   logic [DW-1:0]      data_in;
   logic [DW-1:0]      data_out;
   logic               rd_valid;
   logic [DW*NR-1:0]   values_in;
   logic [DW*NR-1:0]   set_in;
   logic [DW*NR-1:0]   values_out;
   logic [NR-1:0]      wr_strobe;

   int tests = 0;
   int fails = 0;

   sync_register_file #(
      .ADDR_WIDTH(4),
      .DATA_WIDTH(DW),
      .NUM_REGS(NR),
      .RW_MASK(RWM),
      .W1C_MASK(W1M)
   ) dut (
      .clk(clk), .reset(reset), .en(en), .rd(rd), .wr(wr), .be(be),
      .addr(addr), .data_in(data_in), .data_out(data_out), .rd_valid(rd_valid),
      .values_in(values_in), .set_in(set_in), .values_out(values_out),
      .wr_strobe(wr_strobe)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [DW*NR-1:0] act,
                      input logic [DW*NR-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [DW-1:0] m_reg [NR];
   logic [DW-1:0] m_dout;
   logic          m_valid;
   logic [NR-1:0] m_strobe;
   bit            started = 0;

   function automatic bit is_rw(input int i);
      return RWM[i];
   endfunction

   function automatic bit is_w1c(input int i);
      return !RWM[i] && W1M[i];
   endfunction

   always @(posedge clk) begin
      logic [DW-1:0] old [NR];
      logic [DW-1:0] bm;
      int a;
      a = int'(addr);
      bm = {{8{be[1]}}, {8{be[0]}}};
      if (reset) begin
         for (int i = 0; i < NR; i++) m_reg[i] = '0;
         m_dout = '0;
         m_valid = 1'b0;
         m_strobe = '0;
      end else begin
         for (int i = 0; i < NR; i++) old[i] = m_reg[i];
         m_valid = en && rd;
         if (en && rd) begin
            if (a >= NR) m_dout = '0;
            else if (is_rw(a) || is_w1c(a)) m_dout = old[a];
            else m_dout = values_in[a*DW +: DW];
         end
         m_strobe = '0;
         if (en && wr && a < NR) begin
            if (is_rw(a)) begin
               m_reg[a] = (old[a] & ~bm) | (data_in & bm);
               m_strobe[a] = 1'b1;
            end else if (is_w1c(a)) begin
               m_reg[a] = old[a] & ~(data_in & bm);
               m_strobe[a] = 1'b1;
            end
         end
         for (int i = 0; i < NR; i++)
            if (is_w1c(i)) m_reg[i] = m_reg[i] | set_in[i*DW +: DW];
      end
      started = 1;
   end

   always @(posedge clk) begin
      logic [DW*NR-1:0] exp_vo;
      #1;
      if (started) begin
         for (int i = 0; i < NR; i++)
            exp_vo[i*DW +: DW] = (is_rw(i) || is_w1c(i)) ? m_reg[i] : '0;
         chk("values_out", values_out, exp_vo);
         chk("wr_strobe", {{(DW*NR-NR){1'b0}}, wr_strobe}, {{(DW*NR-NR){1'b0}}, m_strobe});
         chk("rd_valid", {{(DW*NR-1){1'b0}}, rd_valid}, {{(DW*NR-1){1'b0}}, m_valid});
         chk("data_out", {{(DW*NR-DW){1'b0}}, data_out}, {{(DW*NR-DW){1'b0}}, m_dout});
      end
   end

   // ---------------- stimulus ----------------
   task automatic acc(input logic r, input logic w, input logic [3:0] a,
                      input logic [DW-1:0] d, input logic [1:0] b);
      en = 1'b1; rd = r; wr = w; addr = a; data_in = d; be = b;
      @(negedge clk);
      en = 1'b0; rd = 1'b0; wr = 1'b0;
   endtask

   task automatic idle();
      @(negedge clk);
   endtask

   task automatic lit(input string name, input logic [DW-1:0] act,
                      input logic [DW-1:0] exp);
      chk(name, {{(DW*NR-DW){1'b0}}, act}, {{(DW*NR-DW){1'b0}}, exp});
   endtask

   initial begin
      // 1: reset wins over a concurrent write and set events
      reset = 1'b1; en = 1'b1; rd = 1'b0; wr = 1'b1; addr = 4'd1;
      data_in = 16'hFFFF; be = 2'b11; set_in = '1;
      for (int i = 0; i < NR; i++) values_in[i*DW +: DW] = 16'h1000 + 16'(i);
      values_in[0 +: DW] = 16'h5A5A;
      @(negedge clk);
      @(negedge clk);
      chk("reset_values_out", values_out, '0);
      lit("reset_rd_valid", {15'd0, rd_valid}, 16'd0);
      lit("reset_wr_strobe", {4'd0, wr_strobe}, 16'd0);
      reset = 1'b0; en = 1'b0; wr = 1'b0; set_in = '0;
      idle();

      // 2: byte-enabled writes to RW reg1
      acc(1'b0, 1'b1, 4'd1, 16'hABCD, 2'b01);
      acc(1'b0, 1'b1, 4'd1, 16'h1200, 2'b10);
      acc(1'b1, 1'b0, 4'd1, 16'h0000, 2'b00);
      lit("rw_bytes_data", data_out, 16'h12CD);
      lit("rw_bytes_valid", {15'd0, rd_valid}, 16'd1);
      idle();
      lit("rw_valid_pulse", {15'd0, rd_valid}, 16'd0);
      lit("rw_data_hold", data_out, 16'h12CD);

      // 3: W1C reg8
      set_in[8*DW +: DW] = 16'h0009;
      idle();
      set_in = '0;
      acc(1'b1, 1'b0, 4'd8, 16'h0000, 2'b00);
      lit("w1c_set", data_out, 16'h0009);
      acc(1'b0, 1'b1, 4'd8, 16'h0001, 2'b11);
      lit("w1c_strobe", {4'd0, wr_strobe}, 16'h0100);
      acc(1'b1, 1'b0, 4'd8, 16'h0000, 2'b00);
      lit("w1c_clear", data_out, 16'h0008);
      set_in[8*DW +: DW] = 16'h0008;
      acc(1'b0, 1'b1, 4'd8, 16'h0008, 2'b11);
      set_in = '0;
      acc(1'b1, 1'b0, 4'd8, 16'h0000, 2'b00);
      lit("w1c_set_beats_clear", data_out, 16'h0008);

      // 4: RO reg0 ignores writes
      acc(1'b0, 1'b1, 4'd0, 16'hFFFF, 2'b11);
      lit("ro_no_strobe", {4'd0, wr_strobe}, 16'd0);
      acc(1'b1, 1'b0, 4'd0, 16'h0000, 2'b00);
      lit("ro_read", data_out, 16'h5A5A);

      // 5: same-cycle read and write of reg4
      acc(1'b0, 1'b1, 4'd4, 16'h0003, 2'b11);
      acc(1'b1, 1'b1, 4'd4, 16'h0007, 2'b11);
      lit("rdwr_old", data_out, 16'h0003);
      lit("rdwr_strobe", {4'd0, wr_strobe}, 16'h0010);
      idle();
      lit("rdwr_strobe_pulse", {4'd0, wr_strobe}, 16'd0);
      acc(1'b1, 1'b0, 4'd4, 16'h0000, 2'b00);
      lit("rdwr_new", data_out, 16'h0007);

      // 6: out-of-range accesses, including the first unimplemented slot
      acc(1'b1, 1'b0, 4'd13, 16'h0000, 2'b00);
      lit("oor_data", data_out, 16'h0000);
      lit("oor_valid", {15'd0, rd_valid}, 16'd1);
      acc(1'b0, 1'b1, 4'd13, 16'hFFFF, 2'b11);
      lit("oor_no_strobe", {4'd0, wr_strobe}, 16'd0);
      acc(1'b1, 1'b0, 4'd1, 16'h0000, 2'b00);
      acc(1'b1, 1'b0, 4'd12, 16'h0000, 2'b00);
      lit("oor_edge", data_out, 16'h0000);

      // en=0 ignores requests; be=0 write still strobes but changes nothing
      en = 1'b0; rd = 1'b1; wr = 1'b1; addr = 4'd1; data_in = 16'hFFFF; be = 2'b11;
      @(negedge clk);
      rd = 1'b0; wr = 1'b0;
      lit("en0_no_valid", {15'd0, rd_valid}, 16'd0);
      acc(1'b0, 1'b1, 4'd5, 16'hFFFF, 2'b00);
      lit("be0_strobe", {4'd0, wr_strobe}, 16'h0020);
      acc(1'b1, 1'b0, 4'd5, 16'h0000, 2'b00);
      lit("be0_value", data_out, 16'h0000);
      // back-to-back reads
      acc(1'b1, 1'b0, 4'd1, 16'h0000, 2'b00);
      acc(1'b1, 1'b0, 4'd4, 16'h0000, 2'b00);
      lit("b2b_second", data_out, 16'h0007);
      lit("b2b_valid", {15'd0, rd_valid}, 16'd1);
      idle();
      idle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
